// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART-fed program loader driving the instruction ROM
// programming port. 8N1 receiver, framing FSM and little-endian byte-to-word
// packer. Frame: 0x55, LEN_LO, LEN_HI, then LEN words of 4 bytes each.
// Optional build macro UPG_CHECKSUM_EN appends a trailing XOR checksum byte
// covering the LEN and data bytes.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;
  // Word index must hold the full 16-bit count and still show overflow past the ROM.
  localparam int unsigned IDX_W   = ((ADDR_W > 16) ? ADDR_W : 16) + 1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd5;
`ifdef UPG_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_TAIL = S_CSUM;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  // Receiver state
  logic             rx_s1, rx_s2, rx_s3;
  logic [1:0]       rx_state, rx_state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       rx_byte, rx_byte_n;
  logic             byte_stb, byte_stb_n;
  logic             ferr, ferr_n;

  // Protocol state
  logic [2:0]       state, state_n;
  logic [15:0]      len, len_n;
  logic [IDX_W-1:0] widx, widx_n, widx_inc;
  logic [1:0]       bcnt, bcnt_n;
  logic [23:0]      word, word_n;
  logic             wen_n, done_n, busy_n, err_n;
  logic [ADDR_W-1:0] adr_n;
  logic [31:0]      dat_n;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]       csum, csum_n;
`endif

  // Two-flop synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
      byte_stb <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      rx_byte  <= rx_byte_n;
      byte_stb <= byte_stb_n;
      ferr     <= ferr_n;
    end
  end

  // Receiver next state: half-bit start check, then one sample per bit period
  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    rx_byte_n  = rx_byte;
    byte_stb_n = 1'b0;
    ferr_n     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx_s2 && rx_s3) rx_state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_W'(HALF_M1)) begin
          cnt_n      = '0;
          bit_idx_n  = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_W'(FULL_M1)) begin
          cnt_n     = '0;
          rx_byte_n = {rx_s2, rx_byte[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(FULL_M1)) begin
          cnt_n      = '0;
          rx_state_n = RX_IDLE;
          if (rx_s2) byte_stb_n = 1'b1;
          else       ferr_n     = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Protocol registers and registered ROM-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SYNC;
      len        <= '0;
      widx       <= '0;
      bcnt       <= '0;
      word       <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_n;
      len        <= len_n;
      widx       <= widx_n;
      bcnt       <= bcnt_n;
      word       <= word_n;
      upg_wen_o  <= wen_n;
      upg_adr_o  <= adr_n;
      upg_dat_o  <= dat_n;
      upg_done_o <= done_n;
      busy_o     <= busy_n;
      err_o      <= err_n;
`ifdef UPG_CHECKSUM_EN
      csum       <= csum_n;
`endif
    end
  end

  assign widx_inc = widx + IDX_W'(1);

  // Protocol next state: frame parsing, word packing and write issue
  always_comb begin
    state_n = state;
    len_n   = len;
    widx_n  = widx;
    bcnt_n  = bcnt;
    word_n  = word;
    wen_n   = 1'b0;
    adr_n   = upg_adr_o;
    dat_n   = upg_dat_o;
    err_n   = err_o;
`ifdef UPG_CHECKSUM_EN
    csum_n  = csum;
`endif
    if (!en_i) begin
      state_n = S_SYNC;
      err_n   = 1'b0;
    end else if (ferr) begin
      err_n = 1'b1;
      if (state != S_SYNC && state != S_DONE) state_n = S_SYNC;
    end else if (byte_stb) begin
      case (state)
        S_SYNC: begin
          if (rx_byte == 8'h55) begin
            state_n = S_LEN0;
            widx_n  = '0;
            bcnt_n  = '0;
`ifdef UPG_CHECKSUM_EN
            csum_n  = '0;
`endif
          end
        end
        S_LEN0: begin
          len_n   = {len[15:8], rx_byte};
          state_n = S_LEN1;
`ifdef UPG_CHECKSUM_EN
          csum_n  = csum ^ rx_byte;
`endif
        end
        S_LEN1: begin
          len_n   = {rx_byte, len[7:0]};
          state_n = ({rx_byte, len[7:0]} == 16'd0) ? S_TAIL : S_DATA;
`ifdef UPG_CHECKSUM_EN
          csum_n  = csum ^ rx_byte;
`endif
        end
        S_DATA: begin
          word_n = {rx_byte, word[23:8]};
          bcnt_n = bcnt + 2'd1;
`ifdef UPG_CHECKSUM_EN
          csum_n = csum ^ rx_byte;
`endif
          if (bcnt == 2'd3) begin
            if ((widx >> ADDR_W) == '0) begin
              wen_n = 1'b1;
              adr_n = widx[ADDR_W-1:0];
              dat_n = {rx_byte, word};
            end else begin
              err_n = 1'b1;
            end
            widx_n = widx_inc;
            if (widx_inc == IDX_W'(len)) state_n = S_TAIL;
          end
        end
`ifdef UPG_CHECKSUM_EN
        S_CSUM: begin
          if (rx_byte == csum) begin
            state_n = S_DONE;
          end else begin
            err_n   = 1'b1;
            state_n = S_SYNC;
          end
        end
`endif
        default: ;
      endcase
    end
    done_n = en_i && (state == S_DONE);
    busy_n = (state_n == S_LEN0) || (state_n == S_LEN1) || (state_n == S_DATA)
`ifdef UPG_CHECKSUM_EN
             || (state_n == S_CSUM)
`endif
             ;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader: directed and randomized frames bit-banged
// onto rx_i, checked against a frame-level reference model.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;
`ifdef UPG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rx;
  logic          wen;
  logic [AW-1:0] adr;
  logic [31:0]   dat;
  logic          done;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .en_i(en), .rx_i(rx),
    .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
    .upg_done_o(done), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Observed write log and pulse timing
  logic [63:0] wq[$];
  int   cyc = 0;
  int   last_wen_cyc = -1;
  int   done_rise_cyc = -1;
  int   dbl = 0;
  int   busy_cyc = 0;
  logic wen_q = 1'b0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wen) begin
      wq.push_back({32'(adr), dat});
      last_wen_cyc <= cyc;
    end
    if (wen && wen_q) dbl <= dbl + 1;
    if (done && !done_q) done_rise_cyc <= cyc;
    if (busy) busy_cyc <= busy_cyc + 1;
    wen_q  <= wen;
    done_q <= done;
  end

  // Frame model state
  logic [7:0]  tx_q[$];
  logic [7:0]  lead_q[$];
  logic [31:0] words_q[$];
  logic [63:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;
  int          model_n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build the byte stream and expected writes for an N-word frame
  function automatic void build_frame(input int n, input bit csum_ok);
    logic [7:0]  x;
    logic [31:0] w;
    tx_q.delete();
    exp_w.delete();
    foreach (lead_q[i]) tx_q.push_back(lead_q[i]);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'(n));
    tx_q.push_back(8'(n >> 8));
    x = 8'(n) ^ 8'(n >> 8);
    for (int k = 0; k < n; k++) begin
      w = words_q[k];
      for (int j = 0; j < 4; j++) begin
        tx_q.push_back(w[8*j +: 8]);
        x = x ^ w[8*j +: 8];
      end
      if (k < (1 << AW)) exp_w.push_back({32'(k), w});
    end
    if (CSUM) tx_q.push_back(csum_ok ? x : (x ^ 8'h03));
    model_n  = n;
    exp_done = !(CSUM && !csum_ok);
    exp_err  = (n > (1 << AW)) || (CSUM && !csum_ok);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic en_pulse();
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    int wbase;
    wbase = wq.size();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk({tag, "_nwr"}, 64'(wq.size() - wbase), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && (wbase + i) < wq.size(); i++)
      chk({tag, "_wr"}, wq[wbase + i], exp_w[i]);
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_err"},  64'(err),  64'(exp_err));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_pulse"}, 64'(dbl), 64'(0));
`ifndef UPG_CHECKSUM_EN
    if (model_n > 0 && exp_w.size() == model_n)
      chk({tag, "_gap"}, 64'(done_rise_cyc - last_wen_cyc), 64'(1));
`endif
  endtask

  initial begin
    int wb;
    int bc;
    rst = 1'b0;
    en  = 1'b1;
    rx  = 1'b1;
    #3;
    chk("rst_wen",  64'(wen),  64'(0));
    chk("rst_adr",  64'(adr),  64'(0));
    chk("rst_dat",  64'(dat),  64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err",  64'(err),  64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame after one word was written
    lead_q.delete();
    words_q = '{32'hDEADBEEF, 32'h12345678};
    build_frame(2, 1'b1);
    wb = wq.size();
    for (int i = 0; i < 7; i++) send_byte(tx_q[i], 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("mid_nwr",  64'(wq.size() - wb), 64'(1));
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_dat",  64'(dat),  64'hDEADBEEF);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dat",  64'(dat),  64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_wen",  64'(wen),  64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wb = wq.size();
    bc = busy_cyc;
    repeat (1000) @(negedge clk);
    #1;
    chk("idle_nwr",  64'(wq.size() - wb), 64'(0));
    chk("idle_busy", 64'(busy_cyc - bc),  64'(0));
    chk("idle_err",  64'(err),  64'(0));
    chk("idle_done", 64'(done), 64'(0));

    // Two-word load
    en_pulse();
    build_frame(2, 1'b1);
    run_frame("two_words");

    // Leading junk bytes before sync
    en_pulse();
    lead_q = '{8'hAA, 8'h00};
    words_q = '{32'h01020304};
    build_frame(1, 1'b1);
    run_frame("junk_lead");
    lead_q.delete();

    // Zero-length load
    en_pulse();
    build_frame(0, 1'b1);
    run_frame("zero_len");

    // Framing error in data, then a clean reload with sticky error
    en_pulse();
    wb = wq.size();
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    chk("ferr_err",  64'(err),  64'(1));
    chk("ferr_busy", 64'(busy), 64'(0));
    chk("ferr_done", 64'(done), 64'(0));
    chk("ferr_nwr",  64'(wq.size() - wb), 64'(0));
    words_q = '{32'h44332211};
    build_frame(1, 1'b1);
    exp_err = 1'b1;
    run_frame("reload");
    en_pulse();
    #1;
    chk("en_clr_done", 64'(done), 64'(0));
    chk("en_clr_err",  64'(err),  64'(0));

`ifdef UPG_CHECKSUM_EN
    // Checksum good and bad
    en_pulse();
    words_q = '{32'h04030201};
    build_frame(1, 1'b1);
    run_frame("csum_ok");
    en_pulse();
    build_frame(1, 1'b0);
    run_frame("csum_bad");
`endif

    // Randomized frames, including index overflow past the ROM and rx glitches
    for (int t = 0; t < 8; t++) begin
      int n;
      bit ok;
      en_pulse();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      lead_q.delete();
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h55) b = 8'hA5;
        lead_q.push_back(b);
      end
      n = (t == 0) ? 6 : int'($urandom_range(0, 6));
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back($urandom);
      ok = (t < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      build_frame(n, ok);
      run_frame($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
